activity_time_tracker: RTL

Parametrised high-activity timer for the heart-rate monitor path. Samples the per-second pulse-rate value (`ppm`) on a one-second enable and accumulates total high-activity seconds. Time counts only after the rate has stayed at or above a threshold for a qualifying window, and hysteresis is applied while a session is active. It sits downstream of the pulse-rate calculator and feeds the display/mux logic with a saturating seconds count.

---
 rtl/activity_pkg.sv | 30 +++
 rtl/activity_time_tracker_sat_accum.sv | 42 ++++
 rtl/activity_time_tracker.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/activity_pkg.sv
// Shared types, default constants and saturating arithmetic for the
// high-activity time tracker.
package activity_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      QUAL   = 2'd1,
      ACTIVE = 2'd2
   } act_state_t;

   localparam int ACT_PPM_W     = 10;
   localparam int ACT_HAT_W     = 16;
   localparam int ACT_THRESH    = 64;
   localparam int ACT_HYST      = 4;
   localparam int ACT_QUAL_SECS = 60;

   // Callers zero-extend operands to 32 bits and pass their own ceiling.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] maxv);
      logic [32:0] sum_s;
      sum_s = {1'b0, a} + {1'b0, b};
      if (sum_s > {1'b0, maxv}) begin
         sat_add = maxv;
      end else begin
         sat_add = sum_s[31:0];
      end
   endfunction

endpackage

// File: rtl/activity_time_tracker_sat_accum.sv
// sat_accum: W-bit accumulator that loads or adds (saturating at all-ones)
// on enabled cycles. W must not exceed 32.
module sat_accum
   import activity_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic [W-1:0] add_val,
   output logic [W-1:0] q
);

   localparam logic [W-1:0] MAX_C = '1;

   logic [W-1:0] q_r;
   logic [W-1:0] sum_s;

   // Saturated sum of the current value and the increment.
   always_comb begin
      sum_s = W'(sat_add(32'(q_r), 32'(add_val), 32'(MAX_C)));
   end

   // Accumulator register: load wins over add, holds when not enabled.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_r <= '0;
      end else if (en) begin
         if (load) begin
            q_r <= load_val;
         end else begin
            q_r <= sum_s;
         end
      end
   end

   assign q = q_r;

endmodule

// File: rtl/activity_time_tracker.sv
// High-activity seconds tracker: IDLE -> QUAL -> ACTIVE with hysteresis.
// Optional longest-session output enabled by ACTIVITY_SESSION_MAX_EN.
module activity_time_tracker
   import activity_pkg::*;
#(
   parameter int PPM_W     = ACT_PPM_W,
   parameter int HAT_W     = ACT_HAT_W,
   parameter int THRESH    = ACT_THRESH,
   parameter int HYST      = ACT_HYST,
   parameter int QUAL_SECS = ACT_QUAL_SECS
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               tick,
   input  logic [PPM_W-1:0]                   ppm,
   output logic [HAT_W-1:0]                   hat,
   output logic                               active,
   output logic [$clog2(QUAL_SECS+1)-1:0]     qual_cnt
`ifdef ACTIVITY_SESSION_MAX_EN
   ,
   output logic [HAT_W-1:0]                   max_session
`endif
);

   localparam int QW = $clog2(QUAL_SECS+1);
   localparam logic [PPM_W-1:0] THRESH_C = PPM_W'(THRESH);
   localparam logic [PPM_W-1:0] HOLD_C   = PPM_W'(THRESH - HYST);
   localparam logic [HAT_W-1:0] QUAL_C   = HAT_W'(QUAL_SECS);
   localparam logic [HAT_W-1:0] ONE_C    = HAT_W'(1);

   act_state_t    state_r, state_nx_s;
   logic [QW-1:0] qual_cnt_r, qual_nx_s;
   logic          active_r;
   logic          high_s, hold_s, qual_last_s;
   logic          hat_en_s;
   logic [HAT_W-1:0] hat_add_s;

   assign high_s      = (ppm >= THRESH_C);
   assign hold_s      = (ppm >= HOLD_C);
   assign qual_last_s = (({1'b0, qual_cnt_r} + (QW+1)'(1)) == (QW+1)'(QUAL_SECS));

   // Next-state, qualifying count and hat increment for a tick cycle.
   always_comb begin
      state_nx_s = state_r;
      qual_nx_s  = qual_cnt_r;
      hat_en_s   = 1'b0;
      hat_add_s  = '0;
      case (state_r)
         IDLE: begin
            if (high_s) begin
               if (QUAL_SECS == 1) begin
                  state_nx_s = ACTIVE;
                  qual_nx_s  = '0;
                  hat_en_s   = 1'b1;
                  hat_add_s  = QUAL_C;
               end else begin
                  state_nx_s = QUAL;
                  qual_nx_s  = QW'(1);
               end
            end else begin
               qual_nx_s = '0;
            end
         end
         QUAL: begin
            if (high_s && qual_last_s) begin
               state_nx_s = ACTIVE;
               qual_nx_s  = '0;
               hat_en_s   = 1'b1;
               hat_add_s  = QUAL_C;
            end else if (high_s) begin
               qual_nx_s = qual_cnt_r + QW'(1);
            end else begin
               state_nx_s = IDLE;
               qual_nx_s  = '0;
            end
         end
         ACTIVE: begin
            if (hold_s) begin
               hat_en_s  = 1'b1;
               hat_add_s = ONE_C;
            end else begin
               state_nx_s = IDLE;
            end
         end
         default: begin
            state_nx_s = IDLE;
            qual_nx_s  = '0;
         end
      endcase
   end

   // State, qualifying count and active flag advance only on ticks.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         qual_cnt_r <= '0;
         active_r   <= 1'b0;
      end else if (tick) begin
         state_r    <= state_nx_s;
         qual_cnt_r <= qual_nx_s;
         active_r   <= (state_nx_s == ACTIVE);
      end
   end

   sat_accum #(.W(HAT_W)) u_hat (
      .clk      (clk),
      .reset    (reset),
      .en       (tick & hat_en_s),
      .load     (1'b0),
      .load_val ('0),
      .add_val  (hat_add_s),
      .q        (hat)
   );

   assign active   = active_r;
   assign qual_cnt = qual_cnt_r;

`ifdef ACTIVITY_SESSION_MAX_EN
   logic             sess_load_s, sess_inc_s;
   logic [HAT_W-1:0] cur_session_s, cur_next_s, max_session_r;

   assign sess_load_s = (state_r != ACTIVE) && (state_nx_s == ACTIVE);
   assign sess_inc_s  = (state_r == ACTIVE) && (state_nx_s == ACTIVE);

   // Value cur_session takes on this tick, so the maximum tracks it on the same edge.
   always_comb begin
      if (sess_load_s) begin
         cur_next_s = QUAL_C;
      end else begin
         cur_next_s = HAT_W'(sat_add(32'(cur_session_s), 32'd1, 32'({HAT_W{1'b1}})));
      end
   end

   sat_accum #(.W(HAT_W)) u_cur_session (
      .clk      (clk),
      .reset    (reset),
      .en       (tick & (sess_load_s | sess_inc_s)),
      .load     (sess_load_s),
      .load_val (QUAL_C),
      .add_val  (ONE_C),
      .q        (cur_session_s)
   );

   // Longest session seen so far.
   always_ff @(posedge clk) begin
      if (reset) begin
         max_session_r <= '0;
      end else if (tick && (sess_load_s || sess_inc_s) && (cur_next_s > max_session_r)) begin
         max_session_r <= cur_next_s;
      end
   end

   assign max_session = max_session_r;
`endif

endmodule
